wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and scoreboard sitting in front of the general-purpose register file write port. Merges single-cycle ALU results with long-latency results (loads, divider) on a valid/ready channel, buffers the latter in a small FIFO, and drives the register file's single write port. Tracks per-register pending-write busy bits so decode can stall on RAW/WAW hazards against outstanding long-latency results.

## Interface
- `REG_ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.
- `FIFO_DEPTH`, 2: long-latency result buffer depth, power of 2, ≥2.
- `STARVE_MAX`, 4: cycles a FIFO head may wait before `wb_stall` asserts.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `alu_wr_en`  in  1  ALU result valid this cycle; no backpressure.
- `alu_wr_addr`  in  REG_ADDR_W  ALU destination register.
- `alu_wr_data`  in  DATA_W  ALU result.
- `ll_valid`  in  1  long-latency result valid.
- `ll_ready`  out  1  FIFO can accept (`!full`).
- `ll_addr`  in  REG_ADDR_W  long-latency destination register.
- `ll_data`  in  DATA_W  long-latency result.
- `issue_en`  in  1  long-latency instruction issued this cycle.
- `issue_rd`  in  REG_ADDR_W  its destination register.
- `chk_addr1`, `chk_addr2`  in  REG_ADDR_W  decode source registers to check.
- `busy1`, `busy2`  out  1  matching register has a pending long-latency write.
- `wb_stall`  out  1  request pipeline to withhold an ALU write next cycle.
- `rf_wr_en`  out  1  register file write enable.
- `rf_wr_addr`  out  REG_ADDR_W  register file write address.
- `rf_wr_data`  out  DATA_W  register file write data.

## Operation
- Reset: FIFO empty, all busy bits 0, age counter 0; hence `ll_ready`=1, `busy1/2`=0, `wb_stall`=0, `rf_wr_en`=0, `rf_wr_addr`=0, `rf_wr_data`=0.
- Accept: `ll_valid && ll_ready` pushes {addr,data} at the clock edge. No bypass from `ll_*` to `rf_wr_*`.
- Arbitration (combinational): `alu_wr_en`=1 → drive ALU fields; else FIFO non-empty → drive FIFO head and pop at edge; else `rf_wr_en`=0, addr/data 0.
- Destination x0: `rf_wr_en` forced 0; a FIFO entry to x0 still pops. Busy bit 0 never set.
- Push and pop same cycle when full: not allowed (`ll_ready`=0 while full, independent of pop).
- Scoreboard: `issue_en && issue_rd!=0` sets `busy[issue_rd]`; a FIFO pop clears `busy[head.addr]`. Set and clear of the same register in one cycle → set wins.
- `busyN = busy[chk_addrN] && !(rf_wr_en && rf_wr_addr==chk_addrN)`: the register file forwards same-cycle writes, so a retiring register reads not-busy. `chk_addrN`=0 → 0.
- Protocol (simulation assertions, no RTL handling): `issue_en` to a busy register; `alu_wr_en` to a busy register; `ll_valid` for a register not busy.
- Age counter: 0 when FIFO empty or head pops; otherwise increments per cycle, saturating at `STARVE_MAX`. `wb_stall` = (age == `STARVE_MAX`), a registered signal.
- If the ALU writes despite `wb_stall`, the ALU still wins; age stays saturated.

## Timing
- Long-latency result accepted at edge N → earliest `rf_wr_en` during cycle N+1 → register written at end of N+1; `busy` reads 0 during N+1 (masked) and from N+2 (cleared).
- ALU path: zero latency, combinational input to `rf_wr_*`.
- `issue_en` at edge N → `busy`=1 from cycle N+1.
- `wb_stall` rises `STARVE_MAX` cycles after the head first waits; falls the cycle after pop.
- Reset asserted mid-operation: FIFO contents and busy bits discarded immediately; outputs return to reset values asynchronously.

## Structure
- Shared package/defines: `REG_ADDR_W`, `DATA_W`, zero-register address, zero word (reuse existing core defines).
- Sub-module `wb_fifo`: synchronous FIFO (push/pop/full/empty/head), pointers with extra wrap bit. Scoreboard, age counter, and arbitration live in `wb_arbiter`.

## Test plan
- Reset: hold `rst_n`=0 → `ll_ready`=1, `rf_wr_en`=0, `busy1/2`=0, `wb_stall`=0.
- Single return: issue rd=5; 3 cycles later `ll_valid` addr=5 data=0xDEADBEEF → next cycle `rf_wr_en`=1, addr 5, data 0xDEADBEEF, `busy1`(chk 5)=0 that cycle and after.
- Contention: FIFO holds x7, `alu_wr_en` x3=0x11 same cycle → RF gets x3/0x11, x7 written the next ALU-idle cycle.
- Backpressure: issue x1,x2,x4; push x1,x2 with ALU busy → `ll_ready`=0; x4 held until first pop, then accepted.
- Starvation: FIFO non-empty, ALU writing every cycle → `wb_stall`=1 after 4 cycles; drop `alu_wr_en` one cycle → pop, `wb_stall`=0 next cycle.
- Edge cases: `ll` to x0 → pops, `rf_wr_en`=0; issue x9 same cycle x9 pops → `busy[9]`=1 after edge.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and constants for the writeback arbiter slice.
// Zero register/word are kept here so every block agrees on what "x0" means.
package wb_arbiter_pkg;

  localparam int WB_REG_ADDR_W = 5;
  localparam int WB_DATA_W     = 32;

  localparam logic [WB_REG_ADDR_W-1:0] ZERO_REG  = '0;
  localparam logic [WB_DATA_W-1:0]     ZERO_WORD = '0;

  // Width needed for a counter that saturates at starve_max (inclusive).
  function automatic int age_width(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency writeback results.
// Head is read combinationally so the arbiter can retire it in the same cycle it is selected.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage is not reset; emptiness is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, buffered long-latency results fill idle slots.
// Also keeps per-register pending-write busy bits and a starvation age counter.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int DATA_W     = WB_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_wr_en,
  input  logic [REG_ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0]     alu_wr_data,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_addr,
  input  logic [DATA_W-1:0]     ll_data,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  wb_stall,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data
);

  localparam int NREGS = 2**REG_ADDR_W;
  localparam int AGE_W = age_width(STARVE_MAX);

  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic [REG_ADDR_W+DATA_W-1:0] fifo_head;
  logic [REG_ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]            head_data;

  logic                         sel_valid;
  logic [REG_ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]            sel_data;

  logic [NREGS-1:0]             busy_reg;
  logic [NREGS-1:0]             busy_next;
  logic [AGE_W-1:0]             age_reg;
  logic [AGE_W-1:0]             age_next;

  wb_fifo #(
    .W     (REG_ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({ll_addr, ll_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign head_addr = fifo_head[DATA_W +: REG_ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];

  // Ready ignores a same-cycle pop so the accept path never depends on ALU activity.
  assign ll_ready  = !fifo_full;
  assign fifo_push = ll_valid && !fifo_full;
  assign fifo_pop  = !alu_wr_en && !fifo_empty;

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = REG_ADDR_W'(ZERO_REG);
    sel_data  = DATA_W'(ZERO_WORD);
    if (alu_wr_en) begin
      sel_valid = 1'b1;
      sel_addr  = alu_wr_addr;
      sel_data  = alu_wr_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_addr  = head_addr;
      sel_data  = head_data;
    end
  end

  // x0 writes are suppressed here; a FIFO entry for x0 still pops above.
  assign rf_wr_en   = sel_valid && (sel_addr != REG_ADDR_W'(ZERO_REG));
  assign rf_wr_addr = sel_addr;
  assign rf_wr_data = sel_data;

  // Clear first, then set, so a same-cycle reissue of the retiring register stays busy.
  always_comb begin
    busy_next = busy_reg;
    if (fifo_pop) busy_next[head_addr] = 1'b0;
    if (issue_en && (issue_rd != REG_ADDR_W'(ZERO_REG))) busy_next[issue_rd] = 1'b1;
  end

  always_comb begin
    age_next = age_reg;
    if (fifo_empty || fifo_pop) begin
      age_next = '0;
    end else if (age_reg != AGE_W'(STARVE_MAX)) begin
      age_next = age_reg + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      age_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      age_reg  <= age_next;
    end
  end

  // The register file forwards same-cycle writes, so a retiring register reads not-busy.
  assign busy1    = busy_reg[chk_addr1] && !(rf_wr_en && (rf_wr_addr == chk_addr1));
  assign busy2    = busy_reg[chk_addr2] && !(rf_wr_en && (rf_wr_addr == chk_addr2));
  assign wb_stall = (age_reg == AGE_W'(STARVE_MAX));

  a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_en && issue_rd != '0) |-> (!busy_reg[issue_rd] || (fifo_pop && head_addr == issue_rd)));

  a_alu_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (alu_wr_en && alu_wr_addr != '0) |-> !busy_reg[alu_wr_addr]);

  a_ll_is_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (ll_valid && ll_addr != '0) |-> busy_reg[ll_addr]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed cycle table, hand-written multi-cycle sequences,
// then constrained-random traffic checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_wr_en;
  logic [AW-1:0] alu_wr_addr;
  logic [DW-1:0] alu_wr_data;
  logic          ll_valid;
  logic          ll_ready;
  logic [AW-1:0] ll_addr;
  logic [DW-1:0] ll_data;
  logic          issue_en;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] chk_addr1;
  logic [AW-1:0] chk_addr2;
  logic          busy1;
  logic          busy2;
  logic          wb_stall;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .REG_ADDR_W (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_wr_en   (alu_wr_en),
    .alu_wr_addr (alu_wr_addr),
    .alu_wr_data (alu_wr_data),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_addr     (ll_addr),
    .ll_data     (ll_data),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .wb_stall    (wb_stall),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data)
  );

  typedef struct {
    logic          ae;  logic [AW-1:0] aa; logic [DW-1:0] ad;
    logic          lv;  logic [AW-1:0] la; logic [DW-1:0] ld;
    logic          ie;  logic [AW-1:0] ir;
    logic [AW-1:0] c1;  logic [AW-1:0] c2;
    logic          er;  logic          ee; logic [AW-1:0] ea; logic [DW-1:0] ed;
    logic          eb1; logic          eb2; logic es;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  function automatic vec_t mk(
    input logic ae, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
    input logic ie, input logic [AW-1:0] ir,
    input logic [AW-1:0] c1, input logic [AW-1:0] c2,
    input logic er, input logic ee, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
    input logic eb1, input logic eb2, input logic es);
    vec_t v;
    v.ae = ae; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.ie = ie; v.ir = ir; v.c1 = c1; v.c2 = c2;
    v.er = er; v.ee = ee; v.ea = ea; v.ed = ed; v.eb1 = eb1; v.eb2 = eb2; v.es = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_in(
    input logic ae, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
    input logic ie, input logic [AW-1:0] ir,
    input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    alu_wr_en = ae; alu_wr_addr = aa; alu_wr_data = ad;
    ll_valid  = lv; ll_addr     = la; ll_data     = ld;
    issue_en  = ie; issue_rd    = ir;
    chk_addr1 = c1; chk_addr2   = c2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic er, input logic ee,
                           input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                           input logic eb1, input logic eb2, input logic es);
    chk({tag, ".ll_ready"}, DW'(ll_ready), DW'(er));
    chk({tag, ".rf_wr_en"}, DW'(rf_wr_en), DW'(ee));
    chk({tag, ".rf_wr_addr"}, DW'(rf_wr_addr), DW'(ea));
    chk({tag, ".rf_wr_data"}, rf_wr_data, ed);
    chk({tag, ".busy1"}, DW'(busy1), DW'(eb1));
    chk({tag, ".busy2"}, DW'(busy2), DW'(eb2));
    chk({tag, ".wb_stall"}, DW'(wb_stall), DW'(es));
  endtask

  vec_t tbl[23];

  // Reference model state
  ent_t          q[$];
  logic [AW-1:0] pend[$];
  bit            busy_m[32];
  int            age_m;

  logic          r_ae, r_lv, r_ie, m_ready, m_pop, m_sv, m_en, m_b1, m_b2;
  logic [AW-1:0] r_aa, r_la, r_ir, r_c1, r_c2, m_sa;
  logic [DW-1:0] r_ad, r_ld, m_sd;
  bit            was_empty;
  ent_t          e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset.ll_ready", DW'(ll_ready), 1);
    chk("reset.rf_wr_en", DW'(rf_wr_en), 0);
    chk("reset.rf_wr_addr", DW'(rf_wr_addr), 0);
    chk("reset.rf_wr_data", rf_wr_data, 0);
    chk("reset.busy1", DW'(busy1), 0);
    chk("reset.busy2", DW'(busy2), 0);
    chk("reset.wb_stall", DW'(wb_stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    //              ae aa ad       lv la ld            ie ir c1 c2 er ee ea ed            b1 b2 st
    tbl[0]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 5, 0, 1, 0, 0, 0,            0, 0, 0);
    tbl[1]  = mk(0, 0, 0,      0, 0, 0,            1, 5, 5, 0, 1, 0, 0, 0,            0, 0, 0);
    tbl[2]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 5, 0, 1, 0, 0, 0,            1, 0, 0);
    tbl[3]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 5, 0, 1, 0, 0, 0,            1, 0, 0);
    tbl[4]  = mk(0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1, 0, 0, 0,            1, 0, 0);
    tbl[5]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 5, 0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 5, 0, 1, 0, 0, 0,            0, 0, 0);
    tbl[7]  = mk(0, 0, 0,      0, 0, 0,            1, 7, 7, 3, 1, 0, 0, 0,            0, 0, 0);
    tbl[8]  = mk(0, 0, 0,      1, 7, 32'h77,       0, 0, 7, 3, 1, 0, 0, 0,            1, 0, 0);
    tbl[9]  = mk(1, 3, 32'h11, 0, 0, 0,            0, 0, 7, 3, 1, 1, 3, 32'h11,       1, 0, 0);
    tbl[10] = mk(0, 0, 0,      0, 0, 0,            0, 0, 7, 3, 1, 1, 7, 32'h77,       0, 0, 0);
    tbl[11] = mk(0, 0, 0,      0, 0, 0,            0, 0, 7, 3, 1, 0, 0, 0,            0, 0, 0);
    tbl[12] = mk(0, 0, 0,      1, 0, 32'hAB,       0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0);
    tbl[13] = mk(0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 32'hAB,       0, 0, 0);
    tbl[14] = mk(0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0);
    tbl[15] = mk(0, 0, 0,      0, 0, 0,            1, 9, 9, 0, 1, 0, 0, 0,            0, 0, 0);
    tbl[16] = mk(0, 0, 0,      1, 9, 32'h99,       0, 0, 9, 0, 1, 0, 0, 0,            1, 0, 0);
    tbl[17] = mk(0, 0, 0,      0, 0, 0,            1, 9, 9, 0, 1, 1, 9, 32'h99,       0, 0, 0);
    tbl[18] = mk(0, 0, 0,      0, 0, 0,            0, 0, 9, 0, 1, 0, 0, 0,            1, 0, 0);
    tbl[19] = mk(0, 0, 0,      1, 9, 32'h98,       0, 0, 9, 0, 1, 0, 0, 0,            1, 0, 0);
    tbl[20] = mk(0, 0, 0,      0, 0, 0,            0, 0, 9, 0, 1, 1, 9, 32'h98,       0, 0, 0);
    tbl[21] = mk(0, 0, 0,      0, 0, 0,            0, 0, 9, 0, 1, 0, 0, 0,            0, 0, 0);
    tbl[22] = mk(1, 0, 32'h55, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 32'h55,       0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      set_in(tbl[i].ae, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld,
             tbl[i].ie, tbl[i].ir, tbl[i].c1, tbl[i].c2);
      @(negedge clk);
      $display("[TB] row %0d: rf_wr_en=%0b addr=%0d data=%08h busy1=%0b",
               i, rf_wr_en, rf_wr_addr, rf_wr_data, busy1);
      check_all($sformatf("row%0d", i), tbl[i].er, tbl[i].ee, tbl[i].ea, tbl[i].ed,
                tbl[i].eb1, tbl[i].eb2, tbl[i].es);
      tick();
    end

    // Backpressure: two results fill the FIFO while the ALU owns the port.
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 2, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 4, 0, 0); tick();
    set_in(1, 10, 32'h10, 1, 1, 32'h101, 0, 0, 1, 4);
    @(negedge clk); check_all("bp.push1", 1, 1, 10, 32'h10, 1, 1, 0); tick();
    set_in(1, 10, 32'h10, 1, 2, 32'h102, 0, 0, 1, 4);
    @(negedge clk); check_all("bp.push2", 1, 1, 10, 32'h10, 1, 1, 0); tick();
    set_in(1, 10, 32'h10, 1, 4, 32'h104, 0, 0, 1, 4);
    @(negedge clk); check_all("bp.full1", 0, 1, 10, 32'h10, 1, 1, 0); tick();
    @(negedge clk); check_all("bp.full2", 0, 1, 10, 32'h10, 1, 1, 0); tick();
    set_in(0, 0, 0, 1, 4, 32'h104, 0, 0, 1, 4);
    @(negedge clk); check_all("bp.pop1", 0, 1, 1, 32'h101, 0, 1, 0); tick();
    set_in(0, 0, 0, 1, 4, 32'h104, 0, 0, 2, 4);
    @(negedge clk); check_all("bp.pop2", 1, 1, 2, 32'h102, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 2, 4);
    @(negedge clk); check_all("bp.pop4", 1, 1, 4, 32'h104, 0, 0, 0); tick();
    @(negedge clk); check_all("bp.idle", 1, 0, 0, 0, 0, 0, 0); tick();
    $display("[TB] backpressure sequence done");

    // Starvation: ALU writes every cycle while x6 waits in the FIFO.
    set_in(0, 0, 0, 0, 0, 0, 1, 6, 0, 0); tick();
    set_in(0, 0, 0, 1, 6, 32'h66, 0, 0, 6, 0); tick();
    for (int k = 0; k < 6; k++) begin
      set_in(1, 11, 32'h1100 + DW'(k), 0, 0, 0, 0, 0, 6, 0);
      @(negedge clk);
      check_all($sformatf("starve%0d", k), 1, 1, 11, 32'h1100 + DW'(k), 1, 0, (k >= SMAX));
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    @(negedge clk); check_all("starve.pop", 1, 1, 6, 32'h66, 0, 0, 1); tick();
    @(negedge clk); check_all("starve.after", 1, 0, 0, 0, 0, 0, 0); tick();
    $display("[TB] starvation sequence done");

    // Asynchronous reset with a result still buffered.
    set_in(0, 0, 0, 0, 0, 0, 1, 12, 0, 0); tick();
    set_in(0, 0, 0, 1, 12, 32'hC0FFEE, 0, 0, 12, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    #1;
    chk("midrst.before_en", DW'(rf_wr_en), 1);
    rst_n = 1'b0;
    #1;
    check_all("midrst", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the queue model.
    q.delete(); pend.delete(); age_m = 0;
    for (int r = 0; r < 32; r++) busy_m[r] = 0;
    for (int n = 0; n < 600; n++) begin
      r_ae = ($urandom_range(0, 99) < ((((n / 50) % 3) == 2) ? 95 : 40));
      r_aa = AW'($urandom_range(0, 31));
      if (busy_m[r_aa]) r_aa = '0;
      r_ad = $urandom;
      r_ir = AW'($urandom_range(1, 31));
      r_ie = ($urandom_range(0, 3) == 0) && !busy_m[r_ir];
      r_lv = 1'b0;
      r_la = AW'($urandom_range(0, 31));
      r_ld = $urandom;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        r_lv = 1'b1;
        r_la = pend[0];
      end
      r_c1 = AW'($urandom_range(0, 31));
      r_c2 = (q.size() > 0) ? q[0].a : AW'($urandom_range(0, 31));
      set_in(r_ae, r_aa, r_ad, r_lv, r_la, r_ld, r_ie, r_ir, r_c1, r_c2);

      m_ready = (q.size() < DEPTH);
      m_pop   = !r_ae && (q.size() > 0);
      m_sv = 1'b0; m_sa = '0; m_sd = '0;
      if (r_ae) begin
        m_sv = 1'b1; m_sa = r_aa; m_sd = r_ad;
      end else if (q.size() > 0) begin
        m_sv = 1'b1; m_sa = q[0].a; m_sd = q[0].d;
      end
      m_en = m_sv && (m_sa != 0);
      m_b1 = busy_m[r_c1] && !(m_en && m_sa == r_c1);
      m_b2 = busy_m[r_c2] && !(m_en && m_sa == r_c2);

      @(negedge clk);
      if (m_en)
        $display("[TB] rnd %0d: write x%0d = %08h", n, m_sa, m_sd);
      check_all($sformatf("rnd%0d", n), m_ready, m_en, m_sa, m_sd, m_b1, m_b2, (age_m == SMAX));

      was_empty = (q.size() == 0);
      if (m_pop) begin
        busy_m[q[0].a] = 0;
        void'(q.pop_front());
      end
      if (r_lv && m_ready) begin
        e.a = r_la; e.d = r_ld;
        q.push_back(e);
        void'(pend.pop_front());
      end
      if (r_ie) begin
        busy_m[r_ir] = 1;
        pend.push_back(r_ir);
      end
      if (was_empty || m_pop) age_m = 0;
      else if (age_m < SMAX) age_m = age_m + 1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
